// File: rtl/dmem_responder.sv
// Data-memory responder for a single-issue memory stage.
// Accepts one load/store at a time, performs it against an internal word
// array with byte-lane masking and sign/zero extension, and returns a
// response that is held until the requester takes it.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   i_req_valid       : request present             o_req_ready : accepting requests
//   i_req_we          : 1 = store, 0 = load
//   i_req_addr        : byte address                i_req_wdata : right-aligned store data
//   i_req_mode        : funct3 size/sign (B, H, W, BU, HU)
//   o_resp_valid      : response present            i_resp_ready : response taken
//   o_resp_rdata      : extended load data (0 on stores and faults)
//   o_resp_err        : access fault
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_mode,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned BYTES = 4 * DEPTH_WORDS;
  localparam int unsigned AW    = $clog2(BYTES);
  localparam int unsigned IW    = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  mode_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic [31:0]   shifted;
  logic          fault_d;
  logic [31:0]   rdata_d;
  logic [3:0]    be_d;
  logic [31:0]   wd_d;
  logic          mem_we;

  assign idx     = addr_q[AW-1:2];
  assign lane    = addr_q[1:0];
  assign rword   = mem_q[idx];
  // Addressed byte/halfword lands in the low bits; halfwords are 2-aligned
  // whenever they are not faulting, so one shift serves both sizes.
  assign shifted = rword >> {lane, 3'b000};

  // Fault detection on the registered request
  always_comb begin
    fault_d = 1'b0;
    case (mode_q)
      3'b011, 3'b110, 3'b111: fault_d = 1'b1;
      3'b100, 3'b101:         if (we_q) fault_d = 1'b1;
      default:                ;
    endcase
    if ((mode_q[1:0] == 2'b01) && addr_q[0]) fault_d = 1'b1;
    if ((mode_q == 3'b010) && (lane != 2'b00)) fault_d = 1'b1;
    if (addr_q >= 32'(BYTES)) fault_d = 1'b1;
  end

  // Load extraction and extension; stores and faults return zero
  always_comb begin
    rdata_d = '0;
    if (!fault_d && !we_q) begin
      case (mode_q)
        3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b010:  rdata_d = rword;
        3'b100:  rdata_d = {24'b0, shifted[7:0]};
        3'b101:  rdata_d = {16'b0, shifted[15:0]};
        default: rdata_d = '0;
      endcase
    end
  end

  // Store lane enables with data replicated across lanes
  always_comb begin
    be_d = 4'b0000;
    wd_d = wdata_q;
    case (mode_q[1:0])
      2'b00: begin
        be_d = 4'b0001 << lane;
        wd_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_d = lane[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{wdata_q[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = wdata_q;
      end
    endcase
  end

  // A reset edge during ACCESS must not commit the store
  assign mem_we = (state_q == S_ACCESS) && we_q && !fault_d && !rst;

  // Word array; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx][8*b +: 8] <= wd_d[8*b +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ready_q && i_req_valid) begin
            we_q    <= i_req_we;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            mode_q  <= i_req_mode;
            ready_q <= 1'b0;
            state_q <= S_ACCESS;
          end else begin
            // First idle cycle after reset raises ready here
            ready_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          rdata_q <= rdata_d;
          err_q   <= fault_d;
          valid_q <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = ready_q;
  assign o_resp_valid = valid_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-addressed reference memory
// plus a per-cycle handshake model, directed literal checks and random traffic.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_mode;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_mode   (i_req_mode),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference memory, one entry per byte
  logic [7:0] mem_m [NB];

  function automatic int acc_size(input logic [2:0] m);
    case (m)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic void model_resp(input logic we, input logic [31:0] a,
                                     input logic [2:0] m,
                                     output logic err, output logic [31:0] rd);
    int size;
    logic [31:0] v;
    size = acc_size(m);
    err  = 1'b0;
    rd   = '0;
    if (size == 0) err = 1'b1;
    else if ((a & 32'(size - 1)) != 0) err = 1'b1;
    if (we && m[2]) err = 1'b1;
    if (a >= 32'(NB)) err = 1'b1;
    if (!err && !we) begin
      v = '0;
      for (int k = size - 1; k >= 0; k--) v = (v << 8) | 32'(mem_m[a + 32'(k)]);
      if (!m[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endfunction

  function automatic void model_commit(input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] m);
    int size;
    size = acc_size(m);
    for (int k = 0; k < size; k++) mem_m[a + 32'(k)] = wd[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  // Expected outputs for the current cycle and the request awaiting its access edge
  logic        e_ready, e_valid, e_err, e_zero;
  logic [31:0] e_rdata;
  bit          m_init = 1'b0;
  bit          pend   = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wd;
  logic [2:0]  p_mode;

  // Compare current outputs, then advance the model across the next rising edge
  always @(negedge clk) begin
    logic        er;
    logic [31:0] rd;
    if (m_init) begin
      chk("req_ready", 32'(o_req_ready), 32'(e_ready));
      chk("resp_valid", 32'(o_resp_valid), 32'(e_valid));
      if (e_valid || e_zero) begin
        chk("resp_rdata", o_resp_rdata, e_rdata);
        chk("resp_err", 32'(o_resp_err), 32'(e_err));
      end
    end
    if (rst) begin
      m_init  = 1'b1;
      e_ready = 1'b0;
      e_valid = 1'b0;
      e_rdata = '0;
      e_err   = 1'b0;
      e_zero  = 1'b1;
      pend    = 1'b0;
    end else if (m_init) begin
      if (pend) begin
        model_resp(p_we, p_addr, p_mode, er, rd);
        if (!er && p_we) model_commit(p_addr, p_wd, p_mode);
        e_valid = 1'b1;
        e_rdata = rd;
        e_err   = er;
        e_zero  = 1'b0;
        pend    = 1'b0;
      end else if (e_valid) begin
        if (i_resp_ready) begin
          e_valid = 1'b0;
          e_ready = 1'b1;
        end
      end else if (e_ready) begin
        if (i_req_valid) begin
          p_we    = i_req_we;
          p_addr  = i_req_addr;
          p_wd    = i_req_wdata;
          p_mode  = i_req_mode;
          pend    = 1'b1;
          e_ready = 1'b0;
        end
      end else begin
        e_ready = 1'b1;
      end
    end
  end

  // One transaction: optional idle gap, request, wait for response, optional backpressure
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] m, input int bp, input int gap,
                     output logic [31:0] rd, output logic e);
    int n;
    int lat;
    rd = '0;
    e  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
      i_resp_ready = 1'($urandom);
      i_req_addr   = $urandom;
    end
    i_resp_ready = 1'b0;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_addr   = a;
    i_req_wdata  = wd;
    i_req_mode   = m;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", o_req_ready);
      i_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'($urandom);
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
    i_req_mode   = 3'($urandom);
    i_resp_ready = 1'($urandom);
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    i_resp_ready = 1'b0;
    if (!o_resp_valid) begin
      tests++; fails++;
      $display("FAIL resp_timeout: resp_valid stayed %b, required 1", o_resp_valid);
      return;
    end
    chk("latency", 32'(lat), 32'd2);
    rd = o_resp_rdata;
    e  = o_resp_err;
    repeat (bp) begin
      @(posedge clk); #1;
      // A competing store that must be ignored while the response is pending
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_mode  = 3'b010;
      i_req_addr  = a & 32'hFFFF_FFFC;
      i_req_wdata = ~wd;
    end
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] prior;
    logic [31:0] a;
    logic        e;
    logic [2:0]  m;
    int          r;

    rst          = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_req_mode   = '0;
    i_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_valid", 32'(o_resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(o_req_ready), 32'd1);

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      txn(1'b1, 32'(4*i), $urandom, 3'b010, 0, 0, rd, e);

    // Store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 0, rd, e);
    chk("sw_err", 32'(e), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 0, 0, rd, e);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 32'd0);

    // Byte lanes and extension
    txn(1'b1, 32'h13, 32'h80, 3'b000, 0, 0, rd, e);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 0, 0, rd, e);
    chk("lw_after_sb", rd, 32'h80ADBEEF);
    txn(1'b0, 32'h13, 32'h0, 3'b000, 0, 0, rd, e);
    chk("lb_sign", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h13, 32'h0, 3'b100, 0, 0, rd, e);
    chk("lbu_zero", rd, 32'h00000080);
    txn(1'b0, 32'h12, 32'h0, 3'b001, 0, 0, rd, e);
    chk("lh_sign", rd, 32'hFFFF80AD);

    // Faults
    txn(1'b0, 32'h11, 32'h0, 3'b001, 0, 0, rd, e);
    chk("lh_mis_err", 32'(e), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
    txn(1'b1, 32'h12, 32'h12345678, 3'b010, 0, 0, rd, e);
    chk("sw_mis_err", 32'(e), 32'd1);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 0, 0, rd, e);
    chk("lw_after_bad_sw", rd, 32'h80ADBEEF);
    txn(1'b0, 32'h10, 32'h0, 3'b011, 0, 0, rd, e);
    chk("mode011_err", 32'(e), 32'd1);
    txn(1'b0, 32'h400, 32'h0, 3'b010, 0, 0, rd, e);
    chk("oob_err", 32'(e), 32'd1);
    chk("oob_rdata", rd, 32'd0);
    txn(1'b1, 32'h10, 32'h0, 3'b101, 0, 0, rd, e);
    chk("store_hu_err", 32'(e), 32'd1);

    // Top-of-array boundary
    txn(1'b1, 32'h3FC, 32'h8123_4567, 3'b010, 0, 0, rd, e);
    chk("sw_top_err", 32'(e), 32'd0);
    txn(1'b0, 32'h3FF, 32'h0, 3'b000, 0, 0, rd, e);
    chk("lb_top", rd, 32'hFFFFFF81);
    txn(1'b0, 32'h3FE, 32'h0, 3'b101, 0, 0, rd, e);
    chk("lhu_top", rd, 32'h00008123);

    // Backpressure with a competing store presented meanwhile
    txn(1'b0, 32'h10, 32'h0, 3'b010, 5, 0, rd, e);
    chk("bp_rdata", rd, 32'h80ADBEEF);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 0, 1, rd, e);
    chk("bp_ignored_req", rd, 32'h80ADBEEF);

    // Reset during the access cycle of a store
    prior       = model_word(32'h20);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 32'h20;
    i_req_wdata = 32'hCAFEF00D;
    i_req_mode  = 3'b010;
    chk("pre_rst_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
    chk("mid_rst_valid", 32'(o_resp_valid), 32'd0);
    chk("mid_rst_rdata", o_resp_rdata, 32'd0);
    chk("mid_rst_err", 32'(o_resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(o_req_ready), 32'd1);
    txn(1'b0, 32'h20, 32'h0, 3'b010, 0, 0, rd, e);
    chk("rst_store_dropped", rd, prior);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      m = 3'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'(NB) + 32'($urandom_range(0, 64));
      else begin
        a = 32'($urandom_range(0, NB - 1));
        if (r < 8) begin
          if (m[1:0] == 2'b10) a = a & 32'hFFFF_FFFC;
          else if (m[1:0] == 2'b01) a = a & 32'hFFFF_FFFE;
        end
      end
      txn(1'($urandom), a, $urandom, m, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), rd, e);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
